viterbi_ctrl: RTL and testbench

- Frame-level sequencer for the rate-1/2, K=3 (4-state) Viterbi decoder.
- Accepts received symbol pairs over a valid/ready handshake and feeds each one to the BMC bank.
- Drives the ACS update and survivor-memory writes for each symbol, then runs traceback over the survivor memory.
- Emits decoded bits in forward order over a second valid/ready handshake.

---
 rtl/viterbi_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_viterbi_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_ctrl.sv
// viterbi_ctrl
// Frame-level sequencer for a rate-1/2, K=3 (4-state) Viterbi decoder.
// It takes received symbol pairs, pulses the ACS bank and survivor memory
// once per symbol, traces back through the survivor memory, and hands out
// the decoded bits oldest first.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   start           begin a frame (only looked at while idle)
//   sym_valid/ready received-symbol handshake, sym_in = {bit1, bit0}
//   bmc_pair        registered symbol presented to the branch-metric bank
//   acs_clear       one-cycle pulse that initialises the path metrics
//   acs_en          one-cycle pulse per accepted symbol
//   surv_wr_en      survivor write strobe (coincident with acs_en)
//   surv_addr       survivor address for writes and reads, 0 when idle
//   surv_rd_en      survivor read strobe; surv_rd_data valid one cycle later
//   best_state      minimum-metric state reported by the ACS bank
//   tb_state        current traceback state
//   dec_valid/ready decoded-bit handshake, dec_bit = decoded bit
//   busy            high whenever a frame is in progress
//   frame_done      one-cycle pulse after the last decoded bit is taken
module viterbi_ctrl #(
  parameter int FRAME_LEN = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sym_valid,
  input  logic [1:0]        sym_in,
  output logic              sym_ready,
  output logic [1:0]        bmc_pair,
  output logic              acs_clear,
  output logic              acs_en,
  output logic              surv_wr_en,
  output logic [ADDR_W-1:0] surv_addr,
  output logic              surv_rd_en,
  input  logic [3:0]        surv_rd_data,
  input  logic [1:0]        best_state,
  output logic [1:0]        tb_state,
  output logic              dec_valid,
  output logic              dec_bit,
  input  logic              dec_ready,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    TB_INIT,
    TB_RD,
    TB_WAIT,
    OUT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0]   LAST_EXT = (ADDR_W + 1)'(FRAME_LEN - 1);

  state_t               state;
  state_t               state_nxt;
  logic [ADDR_W-1:0]    sym_cnt;
  logic [ADDR_W-1:0]    tb_addr;
  logic [ADDR_W-1:0]    out_idx;
  logic                 acs_pend;
  logic                 last_taken;
  logic [FRAME_LEN-1:0] dec_buf;
  logic [ADDR_W:0]      taken_cnt;
  logic                 sym_hs;
  logic                 dec_hs;

  // A symbol registered at the previous edge has not yet been counted in
  // sym_cnt, so the index of the symbol being accepted now is sym_cnt plus
  // the pending one.
  assign taken_cnt = {1'b0, sym_cnt} + {{ADDR_W{1'b0}}, acs_pend};
  assign sym_hs    = sym_valid & sym_ready;
  assign dec_hs    = dec_valid & dec_ready;

  // Next-state and strobe decode. The ACS/survivor strobes come from the
  // acs_pend flag, so they land one cycle after each symbol handshake; the
  // state leaves ACCEPT only during the final symbol's ACS cycle.
  always_comb begin
    state_nxt  = state;
    sym_ready  = 1'b0;
    acs_en     = 1'b0;
    surv_wr_en = 1'b0;
    surv_rd_en = 1'b0;
    surv_addr  = '0;
    dec_valid  = 1'b0;
    dec_bit    = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCEPT;
      end
      ACCEPT: begin
        sym_ready = !last_taken;
        if (acs_pend) begin
          acs_en     = 1'b1;
          surv_wr_en = 1'b1;
          surv_addr  = sym_cnt;
          if (last_taken) state_nxt = TB_INIT;
        end
      end
      TB_INIT: begin
        state_nxt = TB_RD;
      end
      TB_RD: begin
        surv_rd_en = 1'b1;
        surv_addr  = tb_addr;
        state_nxt  = TB_WAIT;
      end
      TB_WAIT: begin
        state_nxt = (tb_addr == '0) ? OUT : TB_RD;
      end
      OUT: begin
        dec_valid = 1'b1;
        dec_bit   = dec_buf[out_idx];
        if (dec_ready && (out_idx == LAST)) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register plus all counters and data registers. Counters saturate
  // at FRAME_LEN-1 instead of wrapping; the traceback walks tb_addr down
  // from the newest survivor column to the oldest, filling dec_buf so the
  // output stage can read it in forward order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sym_cnt    <= '0;
      tb_addr    <= '0;
      out_idx    <= '0;
      acs_pend   <= 1'b0;
      last_taken <= 1'b0;
      dec_buf    <= '0;
      bmc_pair   <= 2'b00;
      tb_state   <= 2'b00;
      acs_clear  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      acs_clear  <= (state == IDLE) && start;
      frame_done <= (state == OUT) && dec_hs && (out_idx == LAST);
      acs_pend   <= sym_hs;

      if (sym_hs) begin
        bmc_pair <= sym_in;
        if (taken_cnt == LAST_EXT) last_taken <= 1'b1;
      end

      if (acs_en && (sym_cnt != LAST)) sym_cnt <= sym_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            sym_cnt    <= '0;
            last_taken <= 1'b0;
          end
        end
        TB_INIT: begin
          tb_state <= best_state;
          tb_addr  <= LAST;
        end
        TB_WAIT: begin
          // The newest input bit is the MSB of the state; the survivor bit
          // supplies the bit that shifts back in as the predecessor's LSB.
          dec_buf[tb_addr] <= tb_state[1];
          tb_state         <= {tb_state[0], surv_rd_data[tb_state]};
          if (tb_addr != '0) tb_addr <= tb_addr - 1'b1;
          else               out_idx <= '0;
        end
        OUT: begin
          if (dec_ready && (out_idx != LAST)) out_idx <= out_idx + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_ctrl.sv
// tb_viterbi_ctrl
// Drives random and fixed messages through viterbi_ctrl. The bench encodes
// each message with the K=3 (7,5) convolutional code, plays the role of the
// BMC/ACS bank and survivor memory around the controller, and expects the
// decoded stream to reproduce the message exactly (no channel errors).
module tb_viterbi_ctrl;

  localparam int FRAME_LEN = 16;
  localparam int ADDR_W    = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              sym_valid;
  logic [1:0]        sym_in;
  logic              sym_ready;
  logic [1:0]        bmc_pair;
  logic              acs_clear;
  logic              acs_en;
  logic              surv_wr_en;
  logic [ADDR_W-1:0] surv_addr;
  logic              surv_rd_en;
  logic [3:0]        surv_rd_data;
  logic [1:0]        best_state;
  logic [1:0]        tb_state;
  logic              dec_valid;
  logic              dec_bit;
  logic              dec_ready;
  logic              busy;
  logic              frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  viterbi_ctrl #(.FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .sym_valid(sym_valid), .sym_in(sym_in), .sym_ready(sym_ready),
    .bmc_pair(bmc_pair), .acs_clear(acs_clear), .acs_en(acs_en),
    .surv_wr_en(surv_wr_en), .surv_addr(surv_addr), .surv_rd_en(surv_rd_en),
    .surv_rd_data(surv_rd_data), .best_state(best_state), .tb_state(tb_state),
    .dec_valid(dec_valid), .dec_bit(dec_bit), .dec_ready(dec_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Code generators 7 (111) and 5 (101); state = {u[t-1], u[t-2]}.
  function automatic logic [1:0] encSym(input logic [1:0] st, input logic u);
    logic c0, c1;
    c0 = u ^ st[1] ^ st[0];
    c1 = u ^ st[0];
    return {c1, c0};
  endfunction

  function automatic int hamming(input logic [1:0] a, input logic [1:0] b);
    return $countones(a ^ b);
  endfunction

  // Behavioural ACS bank and survivor memory surrounding the controller.
  int         pm [4];
  logic [3:0] surv_mem [2**ADDR_W];
  int         best_idx;

  always @(posedge clk) begin
    int         npm [4];
    logic [3:0] sb;
    logic [1:0] ns, pa, pb;
    int         ma, mb;
    if (acs_clear) begin
      pm[0] <= 0; pm[1] <= 64; pm[2] <= 64; pm[3] <= 64;
    end else if (acs_en) begin
      for (int n = 0; n < 4; n++) begin
        ns = 2'(n);
        pa = {ns[0], 1'b0};
        pb = {ns[0], 1'b1};
        ma = pm[pa] + hamming(bmc_pair, encSym(pa, ns[1]));
        mb = pm[pb] + hamming(bmc_pair, encSym(pb, ns[1]));
        if (mb < ma) begin npm[n] = mb; sb[n] = 1'b1; end
        else         begin npm[n] = ma; sb[n] = 1'b0; end
      end
      for (int n = 0; n < 4; n++) pm[n] <= npm[n];
      if (surv_wr_en) surv_mem[surv_addr] <= sb;
    end
    surv_rd_data <= surv_rd_en ? surv_mem[surv_addr] : 4'b0000;
  end

  always_comb begin
    best_idx = 0;
    for (int s = 1; s < 4; s++) if (pm[s] < pm[best_idx]) best_idx = s;
    best_state = 2'(best_idx);
  end

  // Observation of the controller, one ns after the falling edge so both
  // the outputs and the inputs driven for the next rising edge are settled.
  logic [ADDR_W-1:0] acs_addr_q [$];
  logic [1:0]        acs_pair_q [$];
  logic [ADDR_W-1:0] rd_addr_q  [$];
  int                rd_cyc_q   [$];
  logic              out_q      [$];
  int                last_acs_cyc;
  int                first_valid_cyc;
  int                clear_cnt;
  int                done_cnt;
  logic              was_stalled = 1'b0;
  logic              held_bit    = 1'b0;

  always begin
    @(negedge clk);
    #1;
    checkOutput("wr_en_match", surv_wr_en, acs_en);
    if (acs_en) begin
      acs_addr_q.push_back(surv_addr);
      acs_pair_q.push_back(bmc_pair);
      last_acs_cyc = cyc;
    end
    if (surv_rd_en) begin
      rd_addr_q.push_back(surv_addr);
      rd_cyc_q.push_back(cyc);
    end
    if (!acs_en && !surv_rd_en) checkOutput("idle_addr_zero", surv_addr, 0);
    if (acs_clear) clear_cnt++;
    if (frame_done) begin
      done_cnt++;
      checkOutput("done_valid_low", dec_valid, 0);
      checkOutput("done_bit_count", out_q.size(), FRAME_LEN);
    end
    if (dec_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      checkOutput("out_strobe_excl", {acs_en, surv_wr_en, surv_rd_en}, 0);
      if (was_stalled) checkOutput("stall_stable", dec_bit, held_bit);
      if (dec_ready) out_q.push_back(dec_bit);
    end
    was_stalled = dec_valid && !dec_ready;
    held_bit    = dec_bit;
  end

  logic [1:0] exp_syms [FRAME_LEN];

  task automatic encodeFrame(input logic [FRAME_LEN-1:0] msg);
    logic [1:0] st;
    st = 2'b00;
    for (int i = 0; i < FRAME_LEN; i++) begin
      exp_syms[i] = encSym(st, msg[i]);
      st = {msg[i], st[1]};
    end
  endtask

  task automatic clearMonitor();
    acs_addr_q.delete(); acs_pair_q.delete();
    rd_addr_q.delete();  rd_cyc_q.delete(); out_q.delete();
    last_acs_cyc = -1; first_valid_cyc = -1; clear_cnt = 0; done_cnt = 0;
  endtask

  function automatic logic [31:0] outVec();
    return 32'({sym_ready, bmc_pair, acs_clear, acs_en, surv_wr_en, surv_addr,
                surv_rd_en, tb_state, dec_valid, dec_bit, busy, frame_done});
  endfunction

  task automatic startFrame();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checkOutput("acs_clear_pulse", acs_clear, 1);
    checkOutput("busy_after_start", busy, 1);
  endtask

  task automatic sendSymbol(input logic [1:0] s, input bit noise);
    int guard;
    @(negedge clk);
    sym_valid = 1'b1; sym_in = s;
    if (noise) start = 1'($urandom);
    guard = 0;
    while (!sym_ready && guard < 20) begin
      @(negedge clk); guard++;
      if (noise) start = 1'($urandom);
    end
    if (!sym_ready) checkOutput("sym_ready_timeout", sym_ready, 1);
    @(posedge clk);
  endtask

  // One full frame: optional random sym_valid gaps, output backpressure of
  // bp cycles per bit (negative = random 0..3) and optional start noise.
  task automatic applyStimulus(input logic [FRAME_LEN-1:0] msg, input bit gaps,
                               input int bp, input bit noise);
    int got, stall, cur_bp, guard, gap;
    encodeFrame(msg);
    clearMonitor();
    startFrame();
    fork
      begin
        for (int i = 0; i < FRAME_LEN; i++) begin
          if (gaps) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
              @(negedge clk); sym_valid = 1'b0; sym_in = 2'($urandom);
            end
          end
          sendSymbol(exp_syms[i], noise);
        end
        @(negedge clk); sym_valid = 1'b0; start = 1'b0;
      end
      begin
        got = 0; stall = 0; guard = 0;
        cur_bp = (bp < 0) ? $urandom_range(0, 3) : bp;
        while (got < FRAME_LEN && guard < 2000) begin
          @(negedge clk); guard++;
          dec_ready = 1'b0;
          if (dec_valid) begin
            if (noise) start = 1'($urandom);
            if (stall < cur_bp) stall++;
            else begin
              dec_ready = 1'b1; stall = 0; got++;
              cur_bp = (bp < 0) ? $urandom_range(0, 3) : bp;
            end
          end
        end
        if (got < FRAME_LEN) checkOutput("drain_timeout", got, FRAME_LEN);
        @(negedge clk); dec_ready = 1'b0; start = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    checkOutput("frame_done_count", done_cnt, 1);
    checkOutput("acs_clear_count", clear_cnt, 1);
    checkOutput("idle_after_frame", busy, 0);
    checkOutput("acs_count", acs_addr_q.size(), FRAME_LEN);
    for (int i = 0; i < acs_addr_q.size() && i < FRAME_LEN; i++) begin
      checkOutput("acs_addr", acs_addr_q[i], i);
      checkOutput("bmc_pair", acs_pair_q[i], exp_syms[i]);
    end
    checkOutput("rd_count", rd_addr_q.size(), FRAME_LEN);
    for (int i = 0; i < rd_addr_q.size() && i < FRAME_LEN; i++) begin
      checkOutput("rd_addr", rd_addr_q[i], FRAME_LEN - 1 - i);
      if (i > 0) checkOutput("rd_spacing", rd_cyc_q[i] - rd_cyc_q[i-1], 2);
    end
    if (rd_cyc_q.size() > 0) checkOutput("tb_start_latency", rd_cyc_q[0] - last_acs_cyc, 2);
    checkOutput("out_latency", first_valid_cyc - last_acs_cyc, 2 * FRAME_LEN + 2);
    checkOutput("out_count", out_q.size(), FRAME_LEN);
    for (int i = 0; i < out_q.size() && i < FRAME_LEN; i++)
      checkOutput("dec_bit", out_q[i], msg[i]);
  endtask

  // Abort a frame with reset on the 5th traceback read.
  task automatic resetMidTraceback(input logic [FRAME_LEN-1:0] msg);
    int n, guard;
    logic quiet;
    encodeFrame(msg);
    clearMonitor();
    startFrame();
    for (int i = 0; i < FRAME_LEN; i++) sendSymbol(exp_syms[i], 1'b0);
    @(negedge clk); sym_valid = 1'b0;
    n = 0; guard = 0;
    while (n < 5 && guard < 200) begin
      @(negedge clk); guard++;
      if (surv_rd_en) n++;
    end
    checkOutput("rd_before_reset", n, 5);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset_outputs", outVec(), 0);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (dec_valid || busy || frame_done) quiet = 1'b0;
    end
    checkOutput("quiet_after_reset", quiet, 1);
  endtask

  initial begin
    logic [FRAME_LEN-1:0] msg;
    logic [15:0]          known_word;
    rst_n = 1'b0; start = 1'b0; sym_valid = 1'b0; sym_in = 2'b00; dec_ready = 1'b0;
    clearMonitor();
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", outVec(), 0);
    rst_n = 1'b1;

    $display("[TB] all-zero frame");
    applyStimulus('0, 1'b0, 0, 1'b0);

    $display("[TB] known message 1011001110001101");
    known_word = 16'b1011001110001101;
    for (int i = 0; i < FRAME_LEN; i++) msg[i] = known_word[15-i];
    applyStimulus(msg, 1'b0, 0, 1'b0);

    $display("[TB] random message with input gaps");
    msg = FRAME_LEN'($urandom);
    applyStimulus(msg, 1'b1, 0, 1'b0);

    $display("[TB] random message with 3-cycle backpressure");
    msg = FRAME_LEN'($urandom);
    applyStimulus(msg, 1'b0, 3, 1'b0);

    $display("[TB] reset during traceback, then a fresh frame");
    msg = FRAME_LEN'($urandom);
    resetMidTraceback(msg);
    msg = FRAME_LEN'($urandom);
    applyStimulus(msg, 1'b1, -1, 1'b0);

    $display("[TB] start pulses while busy");
    msg = FRAME_LEN'($urandom);
    applyStimulus(msg, 1'b1, -1, 1'b1);

    $display("[TB] mixed random frames");
    for (int k = 0; k < 3; k++) begin
      msg = FRAME_LEN'($urandom);
      applyStimulus(msg, 1'($urandom), -1, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete (checks %0d, errors %0d)", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
